hero_run_sprite_fetch: RTL and testbench

Upstream feeder for the hero running-animation palette lookup. Each pixel clock it decides whether the current VGA coordinate falls inside the hero sprite box and, if so, addresses the synchronous sprite ROM. The ROM's 3-bit colour index goes out with a valid/opaque flag; the downstream palette converts that index to RGB. It also owns the running-animation state machine that steps through the sprite frames, advancing only at frame boundaries.

---
 rtl/hero_run_sprite_fetch_if.sv | 20 ++
 rtl/hero_run_sprite_fetch.sv | 67 ++++++
 tb/tb_hero_run_sprite_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hero_run_sprite_fetch_if.sv
// hero_run_sprite_fetch_if: VGA/game-side inputs, sprite ROM port and palette-side outputs of the hero fetcher
interface hero_run_sprite_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int FRAME_W = 2
);
  logic frame_start, running, facing_left;
  logic [9:0] hero_x, hero_y, DrawX, DrawY;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0] rom_data, pix_index;
  logic pix_valid;
  logic [FRAME_W-1:0] anim_frame;
  modport master(
    output frame_start, running, facing_left, hero_x, hero_y, DrawX, DrawY, rom_data,
    input rom_addr, pix_index, pix_valid, anim_frame
  );
  modport slave(
    input frame_start, running, facing_left, hero_x, hero_y, DrawX, DrawY, rom_data,
    output rom_addr, pix_index, pix_valid, anim_frame
  );
endinterface

// File: rtl/hero_run_sprite_fetch.sv
// hero_run_sprite_fetch: hit-tests the hero box, addresses the sprite ROM and runs the run-animation FSM
module hero_run_sprite_fetch #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W = 12
) (
  input logic Clk,
  input logic Reset_n,
  hero_run_sprite_fetch_if.slave bus
);
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  localparam int HW = FRAME_HOLD > 1 ? $clog2(FRAME_HOLD) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [FW-1:0] anim, frame_nxt;
  logic hit, hit_d1, hit_d2, adv;
  logic [9:0] rx, ry, rxm;
  logic [ADDR_W-1:0] addr, rom_addr;
  logic [2:0] pix_index;
  logic pix_valid;
  assign bus.rom_addr = rom_addr;
  assign bus.pix_index = pix_index;
  assign bus.pix_valid = pix_valid;
  assign bus.anim_frame = anim;
  // frame_nxt is what anim becomes this edge, so pixels fetched on a frame_start cycle use the new frame
  always_comb begin
    adv = bus.frame_start && state == RUN && bus.running;
    state_nxt = bus.frame_start ? (bus.running ? RUN : IDLE) : state;
    hold_nxt = !bus.frame_start ? hold : (adv && hold != HW'(FRAME_HOLD - 1)) ? hold + 1'b1 : '0;
    frame_nxt = !bus.frame_start ? anim
              : !adv ? '0
              : hold != HW'(FRAME_HOLD - 1) ? anim
              : anim == FW'(NUM_FRAMES - 1) ? '0 : anim + 1'b1;
  end
  // 11-bit compares so a box near the right/bottom edge never wraps
  assign hit = {1'b0, bus.DrawX} >= {1'b0, bus.hero_x} && {1'b0, bus.DrawX} < {1'b0, bus.hero_x} + 11'(SPR_W)
            && {1'b0, bus.DrawY} >= {1'b0, bus.hero_y} && {1'b0, bus.DrawY} < {1'b0, bus.hero_y} + 11'(SPR_H);
  assign rx = bus.DrawX - bus.hero_x;
  assign ry = bus.DrawY - bus.hero_y;
  assign rxm = bus.facing_left ? 10'(SPR_W - 1) - rx : rx;
  assign addr = ADDR_W'(32'(frame_nxt) * SPR_W * SPR_H + 32'(ry) * SPR_W + 32'(rxm));
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      hold <= '0;
      anim <= '0;
      rom_addr <= '0;
      hit_d1 <= 1'b0;
      hit_d2 <= 1'b0;
      pix_index <= '0;
      pix_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      hold <= hold_nxt;
      anim <= frame_nxt;
      rom_addr <= hit ? addr : '0;
      hit_d1 <= hit;
      hit_d2 <= hit_d1;
      pix_index <= hit_d2 ? bus.rom_data : '0;
      pix_valid <= hit_d2 && |bus.rom_data;
    end
  end
endmodule

// File: tb/tb_hero_run_sprite_fetch.sv
// tb_hero_run_sprite_fetch: randomized scoreboard bench with a pulse-counting animation model and a sync ROM model
module tb_hero_run_sprite_fetch;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  hero_run_sprite_fetch_if #(.ADDR_W(12), .FRAME_W(2)) bus();
  hero_run_sprite_fetch #(.SPR_W(32), .SPR_H(32), .NUM_FRAMES(4), .FRAME_HOLD(6), .ADDR_W(12)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );
  typedef struct {
    int stamp;
    int a;
    int b;
  } exp_t;
  exp_t addr_q[$];
  exp_t pix_q[$];
  exp_t e;
  logic [2:0] rom [4096];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  bit run_on = 1'b0;
  int pulses = 0;
  always @(posedge Clk) begin
    bus.rom_data <= rom[bus.rom_addr];
    cyc <= cyc + 1;
  end
  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge Clk) if (Reset_n) begin
    while (addr_q.size() > 0 && addr_q[0].stamp <= cyc) begin
      e = addr_q.pop_front();
      chk("rom_addr", int'(bus.rom_addr), e.a);
      chk("anim_frame", int'(bus.anim_frame), e.b);
    end
    while (pix_q.size() > 0 && pix_q[0].stamp <= cyc) begin
      e = pix_q.pop_front();
      chk("pix_index", int'(bus.pix_index), e.a);
      chk("pix_valid", int'(bus.pix_valid), e.b);
    end
  end
  // Drives one pixel cycle, predicts its results, then advances to just after the next edge
  task automatic step(bit fs, bit run, bit fl, int hx, int hy, int dx, int dy);
    int fr, rx, addr;
    bit hit;
    bus.frame_start = fs;
    bus.running = run;
    bus.facing_left = fl;
    bus.hero_x = 10'(hx);
    bus.hero_y = 10'(hy);
    bus.DrawX = 10'(dx);
    bus.DrawY = 10'(dy);
    if (fs) begin
      if (!run_on) begin
        run_on = run;
        pulses = 0;
      end else if (run) pulses++;
      else begin
        run_on = 1'b0;
        pulses = 0;
      end
    end
    fr = run_on ? (pulses / 6) % 4 : 0;
    hit = dx >= hx && dx < hx + 32 && dy >= hy && dy < hy + 32;
    rx = fl ? 31 - (dx - hx) : dx - hx;
    addr = hit ? (fr * 1024 + (dy - hy) * 32 + rx) % 4096 : 0;
    addr_q.push_back('{cyc + 1, addr, fr});
    pix_q.push_back('{cyc + 3, hit ? int'(rom[addr]) : 0, int'(hit && rom[addr] != 3'd0)});
    @(posedge Clk);
    #1;
  endtask
  task automatic rnd_step(bit fs, bit run);
    int hx, hy, dx, dy;
    hx = $urandom_range(0, 1023);
    hy = $urandom_range(0, 1023);
    dx = hx + int'($urandom_range(0, 40)) - 4;
    dy = hy + int'($urandom_range(0, 40)) - 4;
    dx = dx < 0 ? 0 : dx > 1023 ? 1023 : dx;
    dy = dy < 0 ? 0 : dy > 1023 ? 1023 : dy;
    step(fs, run, 1'($urandom_range(0, 1)), hx, hy, dx, dy);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_pix_index"}, int'(bus.pix_index), 0);
    chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_anim_frame"}, int'(bus.anim_frame), 0);
  endtask
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1 chk_zero("rst_mid");
    addr_q.delete();
    pix_q.delete();
    run_on = 1'b0;
    pulses = 0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 3'($urandom_range(0, 7));
    rom[325] = 3'd3;
    rom[1] = 3'd0;
    bus.frame_start = 1'b0;
    bus.running = 1'b0;
    bus.facing_left = 1'b0;
    bus.hero_x = 10'd0;
    bus.hero_y = 10'd0;
    bus.DrawX = 10'd500;
    bus.DrawY = 10'd500;
    repeat (2) @(posedge Clk);
    #1 chk_zero("rst_init");
    Reset_n = 1'b1;
    step(0, 0, 0, 100, 200, 105, 210);
    chk("hit_addr", int'(bus.rom_addr), 325);
    step(0, 0, 0, 100, 200, 99, 210);
    chk("miss_addr", int'(bus.rom_addr), 0);
    step(0, 0, 1, 100, 200, 105, 210);
    chk("mirror_addr", int'(bus.rom_addr), 346);
    chk("hit_pix_index", int'(bus.pix_index), 3);
    chk("hit_pix_valid", int'(bus.pix_valid), 1);
    step(0, 0, 0, 100, 200, 101, 200);
    chk("miss_pix_valid", int'(bus.pix_valid), 0);
    chk("miss_pix_index", int'(bus.pix_index), 0);
    step(0, 0, 0, 620, 200, 639, 200);
    chk("edge_addr", int'(bus.rom_addr), 19);
    step(0, 0, 0, 100, 200, 0, 0);
    chk("transparent_pix_valid", int'(bus.pix_valid), 0);
    for (int k = 1; k <= 25; k++) begin
      repeat ($urandom_range(1, 3)) rnd_step(0, 1'($urandom_range(0, 1)));
      rnd_step(1, 1);
      chk("anim_seq", int'(bus.anim_frame), k < 7 ? 0 : k < 13 ? 1 : k < 19 ? 2 : k < 25 ? 3 : 0);
      if (k == 13) begin
        step(0, 1, 0, 100, 200, 100, 200);
        chk("frame2_addr", int'(bus.rom_addr), 2048);
      end
    end
    for (int k = 26; k <= 37; k++) begin
      rnd_step(0, 1'($urandom_range(0, 1)));
      rnd_step(1, 1);
    end
    chk("pre_stop_frame", int'(bus.anim_frame), 2);
    repeat (3) rnd_step(0, 0);
    chk("stop_hold_frame", int'(bus.anim_frame), 2);
    rnd_step(1, 0);
    chk("stop_idle_frame", int'(bus.anim_frame), 0);
    rnd_step(1, 1);
    chk("restart_frame", int'(bus.anim_frame), 0);
    for (int k = 1; k <= 6; k++) begin
      rnd_step(0, 0);
      rnd_step(1, 1);
    end
    chk("restart_hold_frame", int'(bus.anim_frame), 1);
    repeat (5) step(0, 1, 0, 100, 200, 110, 205);
    do_reset();
    for (int i = 0; i < 1500; i++) rnd_step($urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0);
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    bus.hero_x = 10'd500;
    bus.frame_start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("drain", addr_q.size() + pix_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
